spi_rom_responder: RTL

SPI_ROM_RESPONDER -- requirements
Module: spi_rom_responder

---
 rtl/spi_rom_responder.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_rom_responder.sv
// -----------------------------------------------------------------------------
// spi_rom_responder
//
// Purpose:
//   SPI (mode 0, MSB first) target that behaves like a small read-only serial
//   ROM. The initiator sends opcode 0x03 and a 24-bit address. The responder
//   then streams bytes from an internal byte array, starting at
//   addr[MEM_AW-1:0] and incrementing with wrap, until cs_n rises. The array
//   is filled from the system side through a preload port. All SPI inputs are
//   oversampled in the clk domain.
//
// Optional feature:
//   FAST_READ_EN  - when defined, opcode 0x0B is also accepted. It takes
//                   24 address bits and 8 dummy clocks, then streams data
//                   exactly as 0x03 does. When undefined, 0x0B is rejected
//                   like any other unknown opcode.
//
// Parameters:
//   MEM_AW   - byte-array address width (2**MEM_AW bytes)
//
// Ports:
//   clk      - system clock, all state on rising edge
//   rst      - asynchronous active-high reset
//   sclk     - SPI clock from initiator (asynchronous to clk)
//   cs_n     - SPI chip select, active low
//   mosi     - SPI data from initiator
//   miso     - SPI data to initiator (0 whenever miso_oe is low)
//   miso_oe  - high while streaming data with cs_n low
//   ld_en    - preload write strobe
//   ld_addr  - preload byte index
//   ld_data  - preload byte
//   busy     - high whenever a transaction is in progress
//   cmd_err  - unsupported opcode seen in the current/last transaction
// -----------------------------------------------------------------------------
module spi_rom_responder #(
    parameter int MEM_AW = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic              ld_en,
    input  logic [MEM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy,
    output logic              cmd_err
);

    localparam int         MEM_DEPTH    = 1 << MEM_AW;
    localparam logic [7:0] OP_READ      = 8'h03;
`ifdef FAST_READ_EN
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_IGNORE
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ---------------------------------------------------------------------
    logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic       r_csn_s1,  r_csn_s2,  r_csn_d;
    logic       r_mosi_s1, r_mosi_s2;
    logic [1:0] r_settle;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_csn_fall;
    logic w_sync_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_csn_s1  <= 1'b1;
            r_csn_s2  <= 1'b1;
            r_csn_d   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_settle  <= 2'd0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_csn_s1  <= cs_n;
            r_csn_s2  <= r_csn_s1;
            r_csn_d   <= r_csn_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
            if (r_settle != 2'd3) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    // The cs_n chain comes out of reset at 1. If cs_n is already low when
    // reset is released, that would look like a falling edge even though the
    // real edge happened before reset. Fall detection therefore waits until
    // s2 and the delayed copy both hold post-reset samples (three clocks).
    assign w_sync_ok   = (r_settle == 2'd3);
    assign w_sclk_rise =  r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 &  r_sclk_d;
    assign w_csn_fall  = w_sync_ok & ~r_csn_s2 & r_csn_d;

    // ---------------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------------
    state_t      r_state;
    logic [4:0]  r_bit_cnt;   // bits in CMD/ADDR/DUMMY; rises of current byte in DATA
    logic [23:0] r_shift_in;  // opcode/address shift register
    logic [23:0] r_addr;      // current streaming address (full 24 bits for wrap)
    logic [7:0]  r_tx;        // outgoing byte, MSB drives miso
    logic        r_load;      // r_mem_q holds the next byte to present
    logic        r_cmd_err;
    logic        r_fast;      // current command expects dummy clocks

    state_t      w_state_next;
    logic [4:0]  w_bit_cnt_next;
    logic [23:0] w_shift_next;
    logic [23:0] w_addr_next;
    logic [7:0]  w_tx_next;
    logic        w_load_next;
    logic        w_cmd_err_next;
    logic        w_fast_next;
    logic [23:0] w_in_word;

    // ---------------------------------------------------------------------
    // Byte array with registered read. Reads are issued every clock from the
    // address about to be committed, so a load cycle sees mem[new index].
    // A preload write in the same clock returns the old byte (read-first).
    // ---------------------------------------------------------------------
    logic [7:0]        r_mem [MEM_DEPTH];
    logic [7:0]        r_mem_q;
    logic [MEM_AW-1:0] w_rd_idx;

    assign w_rd_idx = w_addr_next[MEM_AW-1:0];

    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= ld_data;
        end
        r_mem_q <= r_mem[w_rd_idx];
    end

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 5'd0;
            r_shift_in <= 24'd0;
            r_addr     <= 24'd0;
            r_tx       <= 8'd0;
            r_load     <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_fast     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_shift_in <= w_shift_next;
            r_addr     <= w_addr_next;
            r_tx       <= w_tx_next;
            r_load     <= w_load_next;
            r_cmd_err  <= w_cmd_err_next;
            r_fast     <= w_fast_next;
        end
    end

    assign w_in_word = {r_shift_in[22:0], r_mosi_s2};

    // ---------------------------------------------------------------------
    // FSM next state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift_in;
        w_addr_next    = r_addr;
        w_tx_next      = r_load ? r_mem_q : r_tx;
        w_load_next    = 1'b0;
        w_cmd_err_next = r_cmd_err;
        w_fast_next    = r_fast;

        case (r_state)
            S_IDLE: begin
                if (w_csn_fall) begin
                    w_state_next   = S_CMD;
                    w_bit_cnt_next = 5'd0;
                    w_shift_next   = 24'd0;
                    w_cmd_err_next = 1'b0;
                    w_fast_next    = 1'b0;
                end
            end

            S_CMD: begin
                if (w_sclk_rise) begin
                    w_shift_next   = w_in_word;
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd7) begin
                        w_bit_cnt_next = 5'd0;
                        if (w_in_word[7:0] == OP_READ) begin
                            w_state_next = S_ADDR;
                        end
`ifdef FAST_READ_EN
                        else if (w_in_word[7:0] == OP_FAST_READ) begin
                            w_state_next = S_ADDR;
                            w_fast_next  = 1'b1;
                        end
`endif
                        else begin
                            w_state_next   = S_IGNORE;
                            w_cmd_err_next = 1'b1;
                        end
                    end
                end
            end

            S_ADDR: begin
                if (w_sclk_rise) begin
                    w_shift_next   = w_in_word;
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd23) begin
                        w_bit_cnt_next = 5'd0;
                        w_addr_next    = w_in_word;
                        if (r_fast) begin
                            w_state_next = S_DUMMY;
                        end else begin
                            // First byte is fetched now so its MSB is on
                            // miso long before the first data rise.
                            w_state_next = S_DATA;
                            w_load_next  = 1'b1;
                        end
                    end
                end
            end

            S_DUMMY: begin
                if (w_sclk_rise) begin
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd7) begin
                        w_bit_cnt_next = 5'd0;
                        w_state_next   = S_DATA;
                        w_load_next    = 1'b1;
                    end
                end
            end

            S_DATA: begin
                // r_bit_cnt counts data rises of the current byte. The fall
                // that follows the last command/address/dummy rise arrives
                // with the count at 0 and must not shift: the MSB has not
                // been sampled yet.
                if (w_sclk_rise && (r_bit_cnt != 5'd8)) begin
                    w_bit_cnt_next = r_bit_cnt + 5'd1;
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == 5'd8) begin
                        w_bit_cnt_next = 5'd0;
                        w_addr_next    = r_addr + 24'd1;
                        w_load_next    = 1'b1;
                    end else if (r_bit_cnt != 5'd0) begin
                        w_tx_next = {r_tx[6:0], 1'b0};
                    end
                end
            end

            S_IGNORE: begin
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // cs_n high ends any transaction at once; partial bytes are dropped.
        if ((r_state != S_IDLE) && r_csn_s2) begin
            w_state_next   = S_IDLE;
            w_bit_cnt_next = 5'd0;
            w_shift_next   = 24'd0;
            w_load_next    = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign miso_oe = (r_state == S_DATA) & ~r_csn_s2;
    assign miso    = miso_oe & r_tx[7];
    assign busy    = (r_state != S_IDLE);
    assign cmd_err = r_cmd_err;

endmodule
